// File: rtl/rv32i_types.sv
// Shared RV32I datapath types: ALU opcodes, CDB slot and RS records.
package rv32i_types;

   typedef logic [3:0] rob_tag_t;

   typedef enum logic [2:0] {
      alu_add = 3'b000,
      alu_sll = 3'b001,
      alu_sra = 3'b010,
      alu_sub = 3'b011,
      alu_xor = 3'b100,
      alu_srl = 3'b101,
      alu_or  = 3'b110,
      alu_and = 3'b111
   } alu_ops;

   typedef struct packed {
      alu_ops      op;
      logic [31:0] r1;
      logic [31:0] r2;
      rob_tag_t    tag;
   } rs_t;

   typedef struct packed {
      logic        rdy;
      rob_tag_t    tag;
      logic [31:0] data;
   } sal_t;

   typedef struct packed {
      logic        valid;
      alu_ops      op;
      rob_tag_t    tag;
      logic        r1_rdy;
      logic [31:0] r1;
      rob_tag_t    r1_tag;
      logic        r2_rdy;
      logic [31:0] r2;
      rob_tag_t    r2_tag;
   } rs_entry_t;

endpackage

// File: rtl/rs_alloc.sv
// Lowest-free-index priority encoder for reservation-station allocation.
module rs_alloc #(
   parameter int N = 8,
   parameter int W = 3
) (
   input  logic [N-1:0] valid,
   output logic [W-1:0] free_idx,
   output logic         any_free
);

   always_comb begin
      free_idx = '0;
      any_free = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (!valid[i]) begin
            free_idx = W'(i);
            any_free = 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: holds ops until operands arrive on the CDB,
// then presents each ready entry on its own ALU lane for one cycle.
module alu_rs
   import rv32i_types::*;
#(
   parameter int size      = 8,
   parameter int cdb_ports = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            issue_valid,
   input  alu_ops          issue_op,
   input  rob_tag_t        issue_tag,
   input  logic            issue_r1_rdy,
   input  logic [31:0]     issue_r1,
   input  rob_tag_t        issue_r1_tag,
   input  logic            issue_r2_rdy,
   input  logic [31:0]     issue_r2,
   input  rob_tag_t        issue_r2_tag,
   input  sal_t            cdb [cdb_ports],
   output logic            full,
   output rs_t             alu_data [size],
   output logic [size-1:0] alu_ready
);

   localparam int IW = (size > 1) ? $clog2(size) : 1;

   rs_entry_t       r_ent [size];
   rs_entry_t       w_nxt [size];
   rs_entry_t       w_new;
   logic [size-1:0] w_valid;
   logic [IW-1:0]   w_free_idx;
   logic            w_any_free;

   function automatic logic cdb_hit(input rob_tag_t t);
      cdb_hit = 1'b0;
      for (int k = 0; k < cdb_ports; k++)
         if (cdb[k].rdy && cdb[k].tag == t)
            cdb_hit = 1'b1;
   endfunction

   // Scan high to low so the lowest matching slot wins.
   function automatic logic [31:0] cdb_data(input rob_tag_t t);
      cdb_data = '0;
      for (int k = cdb_ports - 1; k >= 0; k--)
         if (cdb[k].rdy && cdb[k].tag == t)
            cdb_data = cdb[k].data;
   endfunction

   rs_alloc #(
      .N (size),
      .W (IW)
   ) u_alloc (
      .valid    (w_valid),
      .free_idx (w_free_idx),
      .any_free (w_any_free)
   );

   assign full = !w_any_free;

   always_comb begin
      for (int i = 0; i < size; i++) begin
         w_valid[i]     = r_ent[i].valid;
         alu_ready[i]   = r_ent[i].valid & r_ent[i].r1_rdy
                        & r_ent[i].r2_rdy;
         alu_data[i].op  = r_ent[i].op;
         alu_data[i].r1  = r_ent[i].r1;
         alu_data[i].r2  = r_ent[i].r2;
         alu_data[i].tag = r_ent[i].tag;
      end
   end

   always_comb begin
      w_new        = '0;
      w_new.valid  = 1'b1;
      w_new.op     = issue_op;
      w_new.tag    = issue_tag;
      w_new.r1_tag = issue_r1_tag;
      w_new.r2_tag = issue_r2_tag;
      w_new.r1_rdy = issue_r1_rdy;
      w_new.r1     = issue_r1;
      w_new.r2_rdy = issue_r2_rdy;
      w_new.r2     = issue_r2;
      if (!issue_r1_rdy && cdb_hit(issue_r1_tag)) begin
         w_new.r1_rdy = 1'b1;
         w_new.r1     = cdb_data(issue_r1_tag);
      end
      if (!issue_r2_rdy && cdb_hit(issue_r2_tag)) begin
         w_new.r2_rdy = 1'b1;
         w_new.r2     = cdb_data(issue_r2_tag);
      end
   end

   // Flush keeps payload but drops valid bits, issue and CDB captures.
   always_comb begin
      for (int i = 0; i < size; i++) begin
         w_nxt[i] = r_ent[i];
         if (flush) begin
            w_nxt[i].valid = 1'b0;
         end else if (r_ent[i].valid) begin
            if (alu_ready[i]) begin
               w_nxt[i].valid = 1'b0;
            end else begin
               if (!r_ent[i].r1_rdy && cdb_hit(r_ent[i].r1_tag)) begin
                  w_nxt[i].r1_rdy = 1'b1;
                  w_nxt[i].r1     = cdb_data(r_ent[i].r1_tag);
               end
               if (!r_ent[i].r2_rdy && cdb_hit(r_ent[i].r2_tag)) begin
                  w_nxt[i].r2_rdy = 1'b1;
                  w_nxt[i].r2     = cdb_data(r_ent[i].r2_tag);
               end
            end
         end
      end
      if (!flush && issue_valid && w_any_free)
         w_nxt[w_free_idx] = w_new;
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < size; i++) begin
         if (!rst)
            r_ent[i] <= '0;
         else
            r_ent[i] <= w_nxt[i];
      end
   end

endmodule

// File: doc/alu_rs.md
# alu_rs

Reservation station directly upstream of the combinational ALU array. It accepts one decoded ALU op per cycle from the issue stage and holds up to `size` ops while their operands are outstanding. It captures operand values broadcast on the common data bus (CDB) and presents each entry whose operands are both ready on its fixed ALU lane. Entry *i* always drives ALU lane *i*, so the ALU result appears on the CDB in the same cycle the entry is presented.

## Interface

**Parameters**
- `size`, 8 — number of entries; equals the ALU lane count.
- `cdb_ports`, 8 — number of CDB result slots snooped per cycle.

**Ports**
- `clk` in 1 — single clock; all state updates on the rising edge.
- `rst` in 1 — reset, synchronous and active-low (0 = reset).
- `flush` in 1 — discard all entries (mispredict recovery).
- `issue_valid` in 1 — issue slot carries an op; ignored when `full`=1.
- `issue_op` in `alu_ops` — ALU operation.
- `issue_tag` in 4 — destination ROB tag.
- `issue_r1_rdy` in 1 — 1: `issue_r1` is a value; 0: wait on `issue_r1_tag`.
- `issue_r1` in 32 — operand 1 value.
- `issue_r1_tag` in 4 — producer ROB tag for operand 1.
- `issue_r2_rdy`, `issue_r2`, `issue_r2_tag` — same as above, for operand 2.
- `cdb` in `sal_t[cdb_ports]` — broadcast results {rdy, tag, data}.
- `full` out 1 — every entry is valid.
- `alu_data` out `rs_t[size]` — {operation, r1, r2, tag} of each entry.
- `alu_ready` out `size` — lane *i* is valid and both operands are ready.

## Operation

- **Entry state:** valid, op, tag, r1_rdy/r1/r1_tag, r2_rdy/r2/r2_tag.
- **Allocation:** when `issue_valid`=1 and `full`=0, write the lowest-indexed invalid entry. `full` is computed from registered valid bits only, so an entry freed this cycle is not reusable until the next cycle.
- **Wake-up:** for each valid entry operand with rdy=0, if any `cdb[k].rdy`=1 and `cdb[k].tag` equals the operand tag, latch `cdb[k].data` and set rdy=1.
  - A slot with `cdb[k].rdy`=0 never matches, regardless of tag value.
  - If several slots match, the lowest k wins. This is legal only for duplicate broadcasts, which the ROB prevents.
- **Issue bypass:** an incoming operand with rdy=0 whose tag matches a CDB slot in the issue cycle is stored as ready with the CDB data.
- **Dispatch:** `alu_ready[i]` = valid[i] & r1_rdy[i] & r2_rdy[i].
  - `alu_data[i]` = {op, r1, r2, tag} of entry *i*, driven combinationally from registers.
  - At the same edge the entry's valid bit clears, so each op is presented for exactly one cycle.
  - The ALU has no stall, so no back-pressure exists.
- **Flush:** clears every valid bit at the next edge.
  - Flush takes priority over a same-cycle issue; the issued op is dropped.
  - CDB captures in the flush cycle are discarded.
- **Reset** (`rst`=0 at an edge) clears all state:
  - all valid bits 0, so `alu_ready`=0 and `full`=0;
  - all payload fields 0, so `alu_data` is all-zero.
- Reset asserted mid-operation behaves like flush plus payload clear.

## Timing

- Issue with both operands ready, cycle N → `alu_ready[i]`=1 in cycle N+1, entry freed at the end of N+1.
- Operand broadcast on the CDB in cycle N (entry already resident) → the entry is dispatchable in N+1.
- Issue-bypass capture in cycle N → dispatchable in N+1.
- Minimum issue-to-dispatch latency is 1 cycle; there is no same-cycle issue-to-ALU path.
- `full` and `alu_ready` depend only on registers; they have no combinational path from issue or CDB inputs.
- Simultaneous dispatch of entry *i* and wake-up of entry *j* in the same cycle is independent.
- Dispatch and issue in the same cycle when `full`=1: the issue is refused (caller holds it).

## Structure

- Shared package `rv32i_types` already holds `alu_ops`, `rs_t` and `sal_t`.
- Add to it:
  - `rs_entry_t` — packed entry record;
  - `rob_tag_t` — 4-bit tag type.
- Sub-module `rs_alloc`: combinational lowest-free-index priority encoder (input valid vector; outputs `free_idx` and `any_free`). `full` = !`any_free`.

## Test plan

- **Ready issue:** reset, issue add tag 3, r1=5, r2=7, both ready → next cycle `alu_ready`=8'h01, lane 0 {add, 5, 7, 3}; the cycle after, `alu_ready`=0.
- **Wake-up:** issue sub tag 2 with r1 waiting on tag 9 and r2=1 ready → no ready; broadcast `cdb[4]`={1, 9, 32'h10} → next cycle lane 0 shows r1=32'h10 and `alu_ready[0]`=1.
- **Bypass:** issue an op waiting on tag 6 while `cdb[0]`={1, 6, 32'hAB} in the same cycle → dispatched next cycle with r1=32'hAB.
- **Fill and allocation:** issue 8 ops all waiting on tag 1 → `full`=1 and a 9th issue is ignored. Broadcast tag 1 → all 8 lanes ready together; `full`=0 the following cycle; the next issue lands in entry 0.
- **Tag 0:** `cdb[k]`={0, 0, x} never wakes an operand waiting on tag 0.
- **Flush and reset:** with 3 waiting entries, assert `flush` together with `issue_valid` → all invalid, the issue dropped. Repeat with `rst`=0 → `alu_data` all zero, `full`=0.
